// File: rtl/ex_stage.sv
// Execute stage: ALU control/ALU, operand forwarding from EX/MEM and MEM/WB,
// and the EX/MEM pipeline register with flush/stall handling.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic              Regdst,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              ALUsrc,
  input  logic              RegWrite,
  input  logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] Immediate,
  input  logic [DATA_W-1:0] read1,
  input  logic [DATA_W-1:0] read2,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] aluresultout,
  output logic [DATA_W-1:0] writedataout,
  output logic [4:0]        writeregout,
  output logic              MemReadout,
  output logic              MemtoRegout,
  output logic              MemWriteout,
  output logic              RegWriteout,
  output logic              zeroout,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB
);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  logic signed [DATA_W-1:0] opa_p0;
  logic signed [DATA_W-1:0] stdata_p0;
  logic signed [DATA_W-1:0] opb_p0;
  logic signed [DATA_W-1:0] res_p0;
  logic        [4:0]        dest_p0;

  // Loads sitting in EX/MEM are never forwarded; their data is not ready yet.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       exm_rw,
    input logic       exm_mr,
    input logic [4:0] exm_rd,
    input logic       mwb_rw,
    input logic [4:0] mwb_rd
  );
    if (exm_rw && !exm_mr && (exm_rd != 5'd0) && (exm_rd == src))
      return 2'b10;
    else if (mwb_rw && (mwb_rd != 5'd0) && (mwb_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic signed [DATA_W-1:0] alu(
    input logic [1:0]               op,
    input logic [5:0]               funct,
    input logic [4:0]               shamt,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b11: r[0] = (a < b);
      default: begin
        case (funct)
          FN_ADD: r = a + b;
          FN_SUB: r = a - b;
          FN_AND: r = a & b;
          FN_OR:  r = a | b;
          FN_SLT: r[0] = (a < b);
          FN_SLL: r = b << shamt;
          default: r = '0;
        endcase
      end
    endcase
    return r;
  endfunction

  always_comb begin
    forwardA = fwd_sel(rs, RegWriteout, MemReadout, writeregout, wb_regwrite, wb_rd);
    forwardB = fwd_sel(rt, RegWriteout, MemReadout, writeregout, wb_regwrite, wb_rd);
  end

  always_comb begin
    case (forwardA)
      2'b10:   opa_p0 = aluresultout;
      2'b01:   opa_p0 = wb_data;
      default: opa_p0 = read1;
    endcase
    case (forwardB)
      2'b10:   stdata_p0 = aluresultout;
      2'b01:   stdata_p0 = wb_data;
      default: stdata_p0 = read2;
    endcase
    opb_p0  = ALUsrc ? Immediate : stdata_p0;
    dest_p0 = Regdst ? rd : rt;
    res_p0  = alu(ALUOp, Immediate[5:0], Immediate[10:6], opa_p0, opb_p0);
  end

  // ---- EX/MEM register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      aluresultout <= '0;
      writedataout <= '0;
      writeregout  <= '0;
      zeroout      <= 1'b0;
      MemReadout   <= 1'b0;
      MemtoRegout  <= 1'b0;
      MemWriteout  <= 1'b0;
      RegWriteout  <= 1'b0;
    end else if (flush || !stall) begin
      aluresultout <= res_p0;
      writedataout <= stdata_p0;
      writeregout  <= dest_p0;
      zeroout      <= (res_p0 == '0);
      MemReadout   <= flush ? 1'b0 : MemRead;
      MemtoRegout  <= flush ? 1'b0 : MemtoReg;
      MemWriteout  <= flush ? 1'b0 : MemWrite;
      RegWriteout  <= flush ? 1'b0 : RegWrite;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed hazard scenarios plus randomized traffic,
// every cycle compared against an instruction-level reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [4:0]  rs, rt, rd;
  logic        Regdst, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite;
  logic [1:0]  ALUOp;
  logic [31:0] Immediate, read1, read2;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] aluresultout, writedataout;
  logic [4:0]  writeregout;
  logic        MemReadout, MemtoRegout, MemWriteout, RegWriteout, zeroout;
  logic [1:0]  forwardA, forwardB;

  int total = 0;
  int bad   = 0;

  // reference copy of the EX/MEM register
  logic [31:0] m_res, m_wd;
  logic [4:0]  m_wr;
  logic        m_mr, m_mtr, m_mw, m_rw, m_z;

  ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .rs(rs), .rt(rt), .rd(rd),
    .Regdst(Regdst), .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUsrc(ALUsrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .Immediate(Immediate),
    .read1(read1), .read2(read2),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .aluresultout(aluresultout), .writedataout(writedataout), .writeregout(writeregout),
    .MemReadout(MemReadout), .MemtoRegout(MemtoRegout), .MemWriteout(MemWriteout),
    .RegWriteout(RegWriteout), .zeroout(zeroout),
    .forwardA(forwardA), .forwardB(forwardB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Which source supplies the newest value of register r
  function automatic logic [1:0] ref_src(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (m_rw && !m_mr && m_wr == r) return 2'b10;
    if (wb_regwrite && wb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_val(input logic [1:0] src, input logic [31:0] rf);
    if (src == 2'b10) return m_res;
    if (src == 2'b01) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] imm,
                                          input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return (sa < sb) ? 32'd1 : 32'd0;
      default: begin
        case (imm[5:0])
          6'd32: return a + b;
          6'd34: return a - b;
          6'd36: return a & b;
          6'd37: return a | b;
          6'd42: return (sa < sb) ? 32'd1 : 32'd0;
          6'd0:  return b << imm[10:6];
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  task automatic chk_outputs();
    chk("alures", aluresultout, m_res);
    chk("wdata", writedataout, m_wd);
    chk("wreg", {27'd0, writeregout}, {27'd0, m_wr});
    chk("ctrl", {28'd0, MemReadout, MemtoRegout, MemWriteout, RegWriteout},
        {28'd0, m_mr, m_mtr, m_mw, m_rw});
    chk("zero", {31'd0, zeroout}, {31'd0, m_z});
  endtask

  // Inputs already driven; check forwarding, clock once, check the register.
  task automatic step();
    logic [1:0]  fa, fb;
    logic [31:0] a, bf, b, r;
    #1;
    fa = ref_src(rs);
    fb = ref_src(rt);
    chk("fwdA", {30'd0, forwardA}, {30'd0, fa});
    chk("fwdB", {30'd0, forwardB}, {30'd0, fb});
    a  = ref_val(fa, read1);
    bf = ref_val(fb, read2);
    b  = ALUsrc ? Immediate : bf;
    r  = ref_alu(ALUOp, Immediate, a, b);
    @(posedge clk);
    if (reset) begin
      {m_res, m_wd, m_wr, m_mr, m_mtr, m_mw, m_rw, m_z} = '0;
    end else if (flush || !stall) begin
      m_res = r;
      m_wd  = bf;
      m_wr  = Regdst ? rd : rt;
      m_z   = (r == 32'd0);
      m_mr  = flush ? 1'b0 : MemRead;
      m_mtr = flush ? 1'b0 : MemtoReg;
      m_mw  = flush ? 1'b0 : MemWrite;
      m_rw  = flush ? 1'b0 : RegWrite;
    end
    #1;
    chk_outputs();
  endtask

  task automatic idle();
    {reset, stall, flush} = '0;
    {rs, rt, rd} = '0;
    {Regdst, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite} = '0;
    ALUOp = 2'b00;
    {Immediate, read1, read2, wb_data} = '0;
    wb_regwrite = 1'b0;
    wb_rd = '0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] v1, input logic [31:0] v2);
    idle();
    ALUOp = 2'b10; Immediate = {26'd0, fn}; Regdst = 1'b1; RegWrite = 1'b1;
    rs = s; rt = t; rd = d; read1 = v1; read2 = v2;
  endtask

  logic [31:0] frozen;
  logic [5:0]  fns [7];

  initial begin
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd13};
    idle();
    reset = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    {m_res, m_wd, m_wr, m_mr, m_mtr, m_mw, m_rw, m_z} = '0;
    chk_outputs();
    chk("rst_fwd", {30'd0, forwardA, forwardB}, 32'd0);

    // R-type add 5+7 into r3
    rtype(6'd32, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    chk("add_res", aluresultout, 32'd12);
    chk("add_wr", {27'd0, writeregout}, 32'd3);

    // back-to-back dependency through EX/MEM
    rtype(6'd32, 5'd1, 5'd5, 5'd2, 32'h8, 32'h8);
    step();
    idle(); ALUOp = 2'b01; RegWrite = 1'b1; rs = 5'd2; rt = 5'd5; rd = 5'd7;
    read1 = 32'd0; read2 = 32'h10;
    #1 chk("b2b_fwdA", {30'd0, forwardA}, 32'd2);
    step();
    chk("b2b_zero", {31'd0, zeroout}, 32'd1);

    // EX/MEM wins over MEM/WB for the store operand
    rtype(6'd32, 5'd1, 5'd9, 5'd4, 32'hAA, 32'h0);
    step();
    idle(); ALUOp = 2'b00; ALUsrc = 1'b1; MemWrite = 1'b1; rs = 5'd1; rt = 5'd4;
    Immediate = 32'd8; read2 = 32'h55;
    wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 32'hBB;
    step();
    chk("st_data", writedataout, 32'hAA);

    // load in EX/MEM is not a forwarding source
    idle(); ALUOp = 2'b00; ALUsrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
    rt = 5'd6; Immediate = 32'd4;
    step();
    idle(); rs = 5'd6; rt = 5'd1;
    #1 chk("lw_none", {30'd0, forwardA}, 32'd0);
    wb_regwrite = 1'b1; wb_rd = 5'd6; wb_data = 32'h123;
    #1 chk("lw_wb", {30'd0, forwardA}, 32'd1);
    step();

    // wraparound subtract and signed slt
    idle(); ALUOp = 2'b01; rs = 5'd10; rt = 5'd11; read1 = 32'd0; read2 = 32'd1;
    step();
    chk("sub_wrap", aluresultout, 32'hFFFFFFFF);
    rtype(6'd42, 5'd10, 5'd11, 5'd12, 32'hFFFFFFFF, 32'd1);
    step();
    chk("slt_neg", aluresultout, 32'd1);

    // r0 target never forwarded
    rtype(6'd32, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4);
    step();
    idle(); wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    #1 chk("r0_fwd", {30'd0, forwardA, forwardB}, 32'd0);
    step();

    // stall for three cycles with changing inputs
    rtype(6'd37, 5'd1, 5'd2, 5'd8, 32'hF0, 32'h0F);
    MemWrite = 1'b1;
    step();
    frozen = aluresultout;
    for (int i = 0; i < 3; i++) begin
      rtype(6'd32, 5'd3, 5'd4, 5'd9, $urandom, $urandom);
      stall = 1'b1;
      step();
    end
    chk("stall_hold", aluresultout, frozen);
    rtype(6'd32, 5'd3, 5'd4, 5'd9, 32'd1, 32'd2);
    MemWrite = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    chk("fl_st_ctrl", {30'd0, RegWriteout, MemWriteout}, 32'd0);
    chk("fl_data", aluresultout, 32'd3);
    rtype(6'd32, 5'd3, 5'd4, 5'd9, 32'd1, 32'd2);
    reset = 1'b1; flush = 1'b1;
    step();
    chk("rst_all", aluresultout | writedataout | {27'd0, writeregout} |
        {27'd0, MemReadout, MemtoRegout, MemWriteout, RegWriteout, zeroout}, 32'd0);

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      {Regdst, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite} = 6'($urandom);
      ALUOp = 2'($urandom);
      Immediate = $urandom;
      Immediate[5:0] = fns[$urandom_range(0, 6)];
      read1 = ($urandom_range(0, 3) == 0) ? read2 : $urandom;
      read2 = $urandom;
      wb_regwrite = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
